// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage encodings and timing constants for the decoder stage controller
// and the PE array that observes global_stage.
package decoder_stage_controller_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE                  = 3'd0,
        STAGE_MEASUREMENT_PREPARING = 3'd1,
        STAGE_MEASUREMENT_LOADING   = 3'd2,
        STAGE_MERGE                 = 3'd3,
        STAGE_GROW                  = 3'd4,
        STAGE_PEELING               = 3'd5,
        STAGE_RESULT_VALID          = 3'd6
    } stage_e;

    // PE stage reg + PE busy/odd reg + reducer reg; grows with reducer pipeline depth.
    localparam int SETTLE_CYCLES = 3;
    localparam int SETTLE_WIDTH  = 2;

endpackage

// File: rtl/decoder_stage_controller_busy_odd_reducer.sv
// Registered OR-reduction of the per-PE busy and odd flags.
module decoder_stage_controller_busy_odd_reducer #(
    parameter int PU_COUNT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PU_COUNT-1:0] i_busy_pe,
    input  logic [PU_COUNT-1:0] i_odd_pe,
    output logic                o_any_busy_q,
    output logic                o_any_odd_q
);

    logic r_any_busy;
    logic r_any_odd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_any_busy <= 1'b0;
            r_any_odd  <= 1'b0;
        end else begin
            r_any_busy <= |i_busy_pe;
            r_any_odd  <= |i_odd_pe;
        end
    end

    assign o_any_busy_q = r_any_busy;
    assign o_any_odd_q  = r_any_odd;

endmodule

// File: rtl/decoder_stage_controller.sv
// Round sequencer broadcasting global_stage to the PE array; paces each
// stage against the registered array-wide busy/odd flags.
//
//   state                       | meaning
//   ----------------------------+------------------------------------------
//   STAGE_IDLE                  | waiting for start, ready=1
//   STAGE_MEASUREMENT_PREPARING | 1 cycle, PEs prepare measurement latch
//   STAGE_MEASUREMENT_LOADING   | 1 cycle, PEs hold the latched measurement
//   STAGE_MERGE                 | settle, then wait for !busy; pick GROW/PEELING
//   STAGE_GROW                  | 1 cycle pulse, counts one iteration
//   STAGE_PEELING               | settle, then wait for !busy
//   STAGE_RESULT_VALID          | 1 cycle, result_valid=1
module decoder_stage_controller
    import decoder_stage_controller_pkg::*;
#(
    parameter int PU_COUNT    = 64,
    parameter int ITER_WIDTH  = 8,
    parameter int MAX_ITER    = 255,
    parameter int CYCLE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    input  logic [PU_COUNT-1:0]    busy_pe,
    input  logic [PU_COUNT-1:0]    odd_pe,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   result_valid,
    output logic [ITER_WIDTH-1:0]  iteration_count,
    output logic                   timeout,
    output logic [CYCLE_WIDTH-1:0] cycle_count
);

    localparam logic [ITER_WIDTH-1:0]   ITER_LIMIT  = ITER_WIDTH'(MAX_ITER);
    localparam logic [SETTLE_WIDTH-1:0] SETTLE_LOAD = SETTLE_WIDTH'(SETTLE_CYCLES);

    stage_e                  r_stage;
    logic                    r_ready;
    logic                    r_result_valid;
    logic [ITER_WIDTH-1:0]   r_iter;
    logic                    r_timeout;
    logic [CYCLE_WIDTH-1:0]  r_cycles;
    logic [SETTLE_WIDTH-1:0] r_settle;
    logic                    w_any_busy;
    logic                    w_any_odd;

    decoder_stage_controller_busy_odd_reducer #(
        .PU_COUNT (PU_COUNT)
    ) u_reducer (
        .clk          (clk),
        .reset        (reset),
        .i_busy_pe    (busy_pe),
        .i_odd_pe     (odd_pe),
        .o_any_busy_q (w_any_busy),
        .o_any_odd_q  (w_any_odd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage        <= STAGE_IDLE;
            r_ready        <= 1'b1;
            r_result_valid <= 1'b0;
            r_iter         <= '0;
            r_timeout      <= 1'b0;
            r_cycles       <= '0;
            r_settle       <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (r_stage != STAGE_IDLE && r_cycles != '1) begin
                r_cycles <= r_cycles + 1'b1;
            end
            case (r_stage)
                STAGE_IDLE: begin
                    if (start) begin
                        r_stage   <= STAGE_MEASUREMENT_PREPARING;
                        r_ready   <= 1'b0;
                        r_iter    <= '0;
                        r_timeout <= 1'b0;
                        r_cycles  <= '0;
                    end
                end
                STAGE_MEASUREMENT_PREPARING: begin
                    r_stage <= STAGE_MEASUREMENT_LOADING;
                end
                STAGE_MEASUREMENT_LOADING: begin
                    r_stage  <= STAGE_MERGE;
                    r_settle <= SETTLE_LOAD;
                end
                STAGE_MERGE: begin
                    // busy is stale until the settle window has drained
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end else if (!w_any_busy) begin
                        if (w_any_odd && r_iter < ITER_LIMIT) begin
                            r_stage <= STAGE_GROW;
                            if (r_iter != '1) begin
                                r_iter <= r_iter + 1'b1;
                            end
                        end else begin
                            if (w_any_odd) begin
                                r_timeout <= 1'b1;
                            end
                            r_stage  <= STAGE_PEELING;
                            r_settle <= SETTLE_LOAD;
                        end
                    end
                end
                STAGE_GROW: begin
                    r_stage  <= STAGE_MERGE;
                    r_settle <= SETTLE_LOAD;
                end
                STAGE_PEELING: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end else if (!w_any_busy) begin
                        r_stage        <= STAGE_RESULT_VALID;
                        r_result_valid <= 1'b1;
                    end
                end
                STAGE_RESULT_VALID: begin
                    r_stage <= STAGE_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_stage <= STAGE_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign global_stage    = r_stage;
    assign ready           = r_ready;
    assign result_valid    = r_result_valid;
    assign iteration_count = r_iter;
    assign timeout         = r_timeout;
    assign cycle_count     = r_cycles;

endmodule

// File: doc/decoder_stage_controller.md
# decoder_stage_controller

Central sequencer that drives `global_stage` to every processing unit in the single-FPGA decoder array. It runs one decoding round per `start` pulse: measurement load, repeated merge/grow iterations until no odd cluster remains, then peeling and a result-valid strobe. Each stage transition is paced against the array's registered `busy` and `odd` outputs. It sits directly upstream of the PE array; the measurement source and error collector key off its stage output.

## Interface
Parameters:
- `PU_COUNT`, 64 — number of processing units observed.
- `ITER_WIDTH`, 8 — width of the grow-iteration counter.
- `MAX_ITER`, 255 — grow iterations allowed before forcing peeling.
- `CYCLE_WIDTH`, 16 — width of the round-latency counter.

Ports:
- `clk` input 1 — clock.
- `reset` input 1 — synchronous, active-high reset.
- `start` input 1 — request a new round; accepted only when `ready`=1.
- `ready` output 1 — high in IDLE.
- `busy_pe` input PU_COUNT — per-PE `busy`.
- `odd_pe` input PU_COUNT — per-PE `odd`.
- `global_stage` output STAGE_WIDTH — stage broadcast to all PEs; registered.
- `result_valid` output 1 — high for the single RESULT_VALID cycle.
- `iteration_count` output ITER_WIDTH — grow stages issued this round.
- `timeout` output 1 — MAX_ITER reached with odd clusters still present.
- `cycle_count` output CYCLE_WIDTH — cycles spent in the last or current round, saturating.

## Operation
- **Stage mapping.** The FSM state equals `global_stage`. States: IDLE, MEASUREMENT_PREPARING, MEASUREMENT_LOADING, MERGE, GROW, PEELING, RESULT_VALID. Stage encodings are the shared STAGE_* constants.
- **Busy/odd reduction.** `any_busy_q` = registered OR of `busy_pe`. `any_odd_q` = registered OR of `odd_pe`. Both reset to 0.
- **IDLE.**
  - `ready`=1.
  - On `start`: go to PREPARING. Clear `iteration_count`, `timeout` and `cycle_count`.
- **PREPARING → LOADING.** Each lasts exactly 1 cycle; the PE latches the measurement on the PREPARING→LOADING edge. LOADING → MERGE.
- **MERGE.**
  - Load `settle_cnt` = SETTLE_CYCLES on entry. Decrement each cycle; ignore `any_busy_q` while `settle_cnt`≠0.
  - Evaluate cycles (`settle_cnt`=0):
    - If `any_busy_q`=1, stay in MERGE.
    - Else if `any_odd_q`=1 and `iteration_count`<MAX_ITER, go to GROW.
    - Else if `any_odd_q`=1 (limit reached), set `timeout`=1 and go to PEELING.
    - Else go to PEELING.
- **GROW.**
  - Lasts exactly 1 cycle; the PE edge-detects its delayed stage.
  - `iteration_count` increments on entry, without wrap.
  - Then go to MERGE.
- **PEELING.** Same settle rule as MERGE. On the first evaluate cycle with `any_busy_q`=0, go to RESULT_VALID.
- **RESULT_VALID.** 1 cycle, `result_valid`=1, then IDLE.
- **`cycle_count`.**
  - Increments every cycle the state is not IDLE, including PREPARING and RESULT_VALID.
  - Saturates at all-ones.
  - Holds its value in IDLE until the next accepted `start`.
- **Boundary conditions.**
  - `start` outside IDLE is ignored.
  - `start` held high re-triggers immediately after RESULT_VALID→IDLE (one IDLE cycle).
  - `reset` mid-round: next cycle is IDLE. Every output takes its reset value.
- **Reset values.** `global_stage`=STAGE_IDLE, `ready`=1, `result_valid`=0, `iteration_count`=0, `timeout`=0, `cycle_count`=0.

## Timing
- **SETTLE_CYCLES = 3.** This covers: PE stage register (1), PE busy/odd register (2), reduction register (3).
- Minimum MERGE and PEELING duration: SETTLE_CYCLES+1 = 4 cycles.
- **Minimum round** (no odd, never busy): PREPARING 1 + LOADING 1 + MERGE 4 + PEELING 4 + RESULT_VALID 1 = 11 cycles.
- Each grow iteration adds GROW 1 + MERGE ≥4 cycles.
- `start` sampled in IDLE → `global_stage`=PREPARING on the next edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Shared package** (`parameters.sv`): STAGE_WIDTH, the STAGE_* encodings (existing), and the new SETTLE_CYCLES.
- **Sub-module `busy_odd_reducer`:** registered OR of the two PU_COUNT vectors. If PU_COUNT grows, it may be pipelined deeper. In that case SETTLE_CYCLES grows by the same number of added stages.

## Test plan
1. **Reset.** Assert `reset` 2 cycles → `global_stage`=IDLE, `ready`=1, `result_valid`=0, counters 0.
2. **Idle round.** `busy_pe`=`odd_pe`=0, pulse `start` → stages PREPARING, LOADING, MERGE×4, PEELING×4, RESULT_VALID×1, IDLE. `cycle_count`=11, `iteration_count`=0.
3. **Single grow.** `odd_pe[5]`=1 until the first GROW is observed, then 0 → exactly one GROW, `iteration_count`=1, `timeout`=0, `cycle_count`=16.
4. **Iteration limit.** With MAX_ITER=4, `odd_pe[0]` stuck at 1 → 4 GROW cycles, `timeout`=1, then PEELING and RESULT_VALID.
5. **Busy hold.** `busy_pe[63]`=1 for 10 cycles from MERGE entry → MERGE exits on the first evaluate cycle after `any_busy_q` falls (MERGE lasts 12 cycles). Repeat in PEELING with the same result.
6. **Reset and start during a round.**
   - `reset` during GROW and again during PEELING → IDLE next cycle, counters 0.
   - `start` pulsed during MERGE → no effect on the sequence.
